sky_rom_arbiter: RTL
====================

# sky_rom_arbiter

Shares the single-port, 1-cycle-latency sky image ROM (16384 × 12-bit RGB, 128×128 texels) between two requesters: port 0 (background scan-out, high priority) and port 1 (block/tile renderer, low priority). Port 0 wins by default. A starvation counter guarantees port 1 a slot after a bounded number of consecutive port-0 wins. Each returned pixel is tagged and steered back to the requester that issued the read. The block sits between the requesters and the ROM instance; the ROM's `address`/`rgb` pins connect directly to `rom_addr`/`rom_rgb`.

## Interface
- `ADDR_W`, 14, ROM address width ({y[6:0], x[6:0]})
- `DATA_W`, 12, RGB444 pixel width
- `MAX_STARVE`, 4, consecutive port-0 grants tolerated while port 1 is waiting (1..15)

- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `p0_req`  in  1  port 0 read request; level, sampled each cycle
- `p0_addr`  in  ADDR_W  port 0 address, valid while `p0_req`=1
- `p0_gnt`  out  1  port 0 request accepted this cycle (combinational)
- `p0_valid`  out  1  one-cycle pulse: `p0_rgb` holds data for an accepted port-0 read
- `p0_rgb`  out  DATA_W  port 0 read data (registered)
- `p1_req`, `p1_addr`, `p1_gnt`, `p1_valid`, `p1_rgb`: same as port 0, for port 1
- `rom_addr`  out  ADDR_W  address to ROM (combinational mux)
- `rom_rgb`  in  DATA_W  ROM data; reflects `rom_addr` of the previous cycle

## Operation
- Handshake: a read is accepted in cycle N iff `pX_req`=1 and `pX_gnt`=1 in cycle N. The requester holds `req`/`addr` until granted, and may issue back-to-back reads (one per cycle).
- Grant rule, evaluated each cycle:
  - `p1_gnt` = `p1_req` & (!`p0_req` | `starve_cnt` == MAX_STARVE)
  - `p0_gnt` = `p0_req` & !`p1_gnt`
  - At most one grant per cycle.
- `starve_cnt` (4-bit register):
  - increments on a cycle with `p0_gnt` & `p1_req`
  - clears on `p1_gnt` or `p1_req`=0
  - otherwise holds
  - saturates at MAX_STARVE
- `rom_addr` = `p0_addr` if `p0_gnt`; `p1_addr` if `p1_gnt`; otherwise the last granted address (holding register, no toggling when idle).
- Return pipeline, 2 stages of tag (`valid`, `port`):
  - stage 1 captures the grant at the edge ending cycle N
  - at the edge ending cycle N+1, `rom_rgb` is written into `pX_rgb` of the tagged port and `pX_valid` is set for one cycle
  - the other port's `rgb` holds its value; its `valid` is 0
- Data registers hold their last value between pulses.

## Timing
- Read latency: grant in cycle N → `pX_valid`=1 with data in cycle N+2. Throughput is 1 read/cycle total across both ports.
- Reset (`rst_n`=0, async):
  - `p0_gnt`=`p1_gnt`=0 (forced while in reset)
  - `p0_valid`=`p1_valid`=0, `p0_rgb`=`p1_rgb`=0
  - `rom_addr`=0, `starve_cnt`=0, pipeline tags cleared
- Reset asserted mid-operation: in-flight reads are dropped. No `valid` pulse appears after reset deassertion unless a new grant occurs.
- Simultaneous requests with `starve_cnt` < MAX_STARVE: port 0 is granted.
- Simultaneous requests with `starve_cnt` == MAX_STARVE: port 1 is granted, and the counter clears next cycle.
- With both ports continuously requesting, the grant pattern repeats with period MAX_STARVE+1: MAX_STARVE port-0 grants, then 1 port-1 grant.
- A port-1 request alone is granted in the same cycle it is asserted; the counter stays 0.
- Requester drops `req` without a grant: nothing is issued, and no `valid` pulse follows.

## Test plan
All tests use a bench ROM model with 1-cycle registered read, `rom[a] = a[11:0]`.
- Single port-0 read: `p0_addr`=0x0123 for 1 cycle from reset → `p0_gnt`=1 in cycle 0, `p0_valid`=1 and `p0_rgb`=0x123 in cycle 2, `p1_valid` stays 0.
- Back-to-back port-1 burst: `p1_addr`=0x3FFD, 0x3FFE, 0x3FFF on consecutive cycles → 3 consecutive `p1_valid` pulses with 0xFFD, 0xFFE, 0xFFF, no gaps.
- Starvation (MAX_STARVE=4): both ports request continuously for 20 cycles → grants P0,P0,P0,P0,P1 repeated; exactly 4 `p1_valid` pulses; each pulse's data matches the port-1 address held at its grant.
- Data steering: alternate grants between the ports with distinct addresses → each `pX_rgb` changes only on its own `valid` cycle, and no data crosses ports.
- Async reset mid-flight: grant port 0 at cycle 0, assert `rst_n`=0 mid-cycle 1 → outputs go to 0 immediately; after release with no requests, no `valid` pulse for 5 cycles.
- Idle hold: after one port-1 read of 0x0456, both `req`=0 for 10 cycles → `rom_addr` holds 0x0456, no grants, no `valid` pulses.

Source files
------------

// File: rtl/sky_rom_arbiter_if.sv
// sky_rom_arbiter_if
// Bundles the two requester ports and the ROM pins of the sky image ROM
// arbiter.
//   p0_* / p1_* : requester ports. req/addr come in; gnt, valid and rgb go out.
//   rom_addr    : address presented to the ROM.
//   rom_rgb     : ROM data, returned one cycle after rom_addr.
// Handshake: a read is accepted in any cycle where pX_req and pX_gnt are both
// 1. The requester holds req/addr steady until it is granted, and may issue a
// new read every cycle. Data returns on pX_rgb two cycles after the grant,
// qualified by a one-cycle pX_valid pulse. There is no backpressure on returns.
// The 'slave' modport is the arbiter side. The 'master' modport is the
// requester/ROM side.
interface sky_rom_arbiter_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 12
);
   logic              p0_req;
   logic [ADDR_W-1:0] p0_addr;
   logic              p0_gnt;
   logic              p0_valid;
   logic [DATA_W-1:0] p0_rgb;
   logic              p1_req;
   logic [ADDR_W-1:0] p1_addr;
   logic              p1_gnt;
   logic              p1_valid;
   logic [DATA_W-1:0] p1_rgb;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_rgb;

   modport slave (
      input  p0_req, p0_addr, p1_req, p1_addr, rom_rgb,
      output p0_gnt, p0_valid, p0_rgb, p1_gnt, p1_valid, p1_rgb, rom_addr
   );

   modport master (
      output p0_req, p0_addr, p1_req, p1_addr, rom_rgb,
      input  p0_gnt, p0_valid, p0_rgb, p1_gnt, p1_valid, p1_rgb, rom_addr
   );
endinterface

// File: rtl/sky_rom_arbiter.sv
// sky_rom_arbiter
// Shares the single-port sky image ROM between two requesters.
// The ROM has a 1-cycle read latency, 16384 x 12-bit.
//   - Port 0 is background scan-out and has high priority.
//   - Port 1 is the tile renderer and has low priority.
// Port 0 wins by default. A starvation counter forces a port-1 grant after
// MAX_STARVE consecutive port-0 wins while port 1 waits. Returned pixels are
// steered back to the port that issued the read.
// Ports:
//   clk   : system clock; all logic runs on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sky_rom_arbiter_if.slave (requester ports + ROM pins)
module sky_rom_arbiter #(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 12,
   parameter int MAX_STARVE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   sky_rom_arbiter_if.slave    bus
);

   localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

   logic [3:0]        starve_cnt;
   logic [ADDR_W-1:0] addr_hold;
   logic              s1_valid;
   logic              s1_port;
   logic              p0_gnt;
   logic              p1_gnt;
   logic              p0_valid_q;
   logic              p1_valid_q;
   logic [DATA_W-1:0] p0_rgb_q;
   logic [DATA_W-1:0] p1_rgb_q;

   // Grants are combinational so a lone request is served in its own cycle.
   // rst_n gates them so nothing is accepted while reset is held.
   always_comb begin
      p1_gnt = rst_n & bus.p1_req & (~bus.p0_req | (starve_cnt == STARVE_LIMIT));
      p0_gnt = rst_n & bus.p0_req & ~p1_gnt;
   end

   // When no port is granted, the last granted address is held so the ROM
   // address pins do not toggle while idle.
   always_comb begin
      bus.rom_addr = addr_hold;
      if (p0_gnt)
         bus.rom_addr = bus.p0_addr;
      else if (p1_gnt)
         bus.rom_addr = bus.p1_addr;
   end

   assign bus.p0_gnt   = p0_gnt;
   assign bus.p1_gnt   = p1_gnt;
   assign bus.p0_valid = p0_valid_q;
   assign bus.p1_valid = p1_valid_q;
   assign bus.p0_rgb   = p0_rgb_q;
   assign bus.p1_rgb   = p1_rgb_q;

   // Counts port-0 wins while port 1 is waiting. It clears as soon as port 1
   // is served or stops asking. It saturates at the limit; at that point the
   // grant logic hands the next slot to port 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_cnt <= '0;
      else if (p1_gnt || !bus.p1_req)
         starve_cnt <= '0;
      else if (p0_gnt && (starve_cnt != STARVE_LIMIT))
         starve_cnt <= starve_cnt + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         addr_hold <= '0;
      else if (p0_gnt || p1_gnt)
         addr_hold <= bus.rom_addr;
   end

   // Stage 1 tag: records which port owns the read now in flight in the ROM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_port  <= 1'b0;
      end else begin
         s1_valid <= p0_gnt | p1_gnt;
         s1_port  <= p1_gnt;
      end
   end

   // Stage 2: the ROM data for the tagged read is present on rom_rgb now.
   // Only the owning port's data register is loaded. The other port keeps
   // its last pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_valid_q <= 1'b0;
         p1_valid_q <= 1'b0;
         p0_rgb_q   <= '0;
         p1_rgb_q   <= '0;
      end else begin
         p0_valid_q <= s1_valid & ~s1_port;
         p1_valid_q <= s1_valid & s1_port;
         if (s1_valid && !s1_port)
            p0_rgb_q <= bus.rom_rgb;
         if (s1_valid && s1_port)
            p1_rgb_q <= bus.rom_rgb;
      end
   end

endmodule
